// File: rtl/apb_uart_regs_fifo.sv
// UART APB3 register file with TX/RX FIFOs, sticky W1C status and a level interrupt.
// Zero-wait-state slave: side effects land on the edge that closes the access phase.

module uart_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    input  logic             flush,
    output logic [W-1:0]     head,
    output logic [PTR_W:0]   level,
    output logic             empty,
    output logic             full
);
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (PTR_W+1)'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rptr];

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (do_push && !flush) mem[wptr] <= din;
    end
endmodule

module apb_uart_regs_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [4:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              tx_done_pulse,
    input  logic              parity_err_pulse,
    output logic [4:0]        cfg_out,
    output logic              irq
);
    localparam logic [2:0] A_TXDATA = 3'd0, A_RXDATA = 3'd1, A_CFG = 3'd2,
                           A_CTRL = 3'd3, A_STATUS = 3'd4, A_IRQEN = 3'd5;

    logic [4:0] cfg_q, irq_en_q, sticky_q, sticky_set, w1c;
    logic       tx_en_q, rx_en_q;

    logic              access, rd, wr, addr_bad;
    logic [2:0]        idx;
    logic              wr_ok, rd_ok, tx_push, tx_pop, tx_ovf, rx_pop, rx_under;
    logic              ctrl_wr, tx_flush, rx_flush, rx_push_req, rx_ok, rx_ovr;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [PTR_W:0]    tx_level, rx_level;
    logic              tx_empty, tx_full, rx_empty, rx_full;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign access   = psel & penable;
    assign rd       = access & ~pwrite;
    assign wr       = access & pwrite;
    assign idx      = paddr[4:2];
    assign addr_bad = (paddr[1:0] != 2'b00) || (idx > A_IRQEN);

    assign tx_pop   = tx_valid & tx_ready;
    assign tx_ovf   = wr & ~addr_bad & (idx == A_TXDATA) & tx_full & ~tx_pop;
    assign rx_under = rd & ~addr_bad & (idx == A_RXDATA) & rx_empty;

    assign pready  = access;
    assign pslverr = access & (addr_bad | (rd & idx == A_TXDATA) | (wr & idx == A_RXDATA)
                               | tx_ovf | rx_under);

    assign wr_ok    = wr & ~pslverr;
    assign rd_ok    = rd & ~pslverr;
    assign tx_push  = wr_ok & (idx == A_TXDATA);
    assign rx_pop   = rd_ok & (idx == A_RXDATA);
    assign ctrl_wr  = wr_ok & (idx == A_CTRL);
    assign tx_flush = ctrl_wr & pwdata[2];
    assign rx_flush = ctrl_wr & pwdata[3];

    // An APB pop in the same cycle frees the slot, so a full RX FIFO does not overrun.
    assign rx_push_req = rx_valid & rx_en_q;
    assign rx_ovr      = rx_push_req & rx_full & ~rx_pop;
    assign rx_ok       = rx_push_req & ~rx_flush & (~rx_full | rx_pop);

    uart_fifo #(.W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
        .pclk(pclk), .preset(preset), .push(tx_push), .din(pwdata[DATA_W-1:0]),
        .pop(tx_pop), .flush(tx_flush), .head(tx_head), .level(tx_level),
        .empty(tx_empty), .full(tx_full)
    );

    uart_fifo #(.W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
        .pclk(pclk), .preset(preset), .push(rx_push_req), .din(rx_data),
        .pop(rx_pop), .flush(rx_flush), .head(rx_head), .level(rx_level),
        .empty(rx_empty), .full(rx_full)
    );

    assign tx_valid = ~tx_empty & tx_en_q;
    assign tx_data  = tx_head;
    assign cfg_out  = cfg_q;
    assign irq      = |(sticky_q & irq_en_q);

    assign sticky_set = {tx_ovf, rx_ovr, parity_err_pulse, rx_ok, tx_done_pulse};
    assign w1c        = (wr_ok && idx == A_STATUS) ? pwdata[4:0] : 5'd0;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cfg_q    <= '0;
            irq_en_q <= '0;
            sticky_q <= '0;
            tx_en_q  <= 1'b0;
            rx_en_q  <= 1'b0;
        end else begin
            // Set terms are OR'd after the clear so a coincident event wins.
            sticky_q <= (sticky_q & ~w1c) | sticky_set;
            if (wr_ok && idx == A_CFG)   cfg_q    <= pwdata[4:0];
            if (wr_ok && idx == A_IRQEN) irq_en_q <= pwdata[4:0];
            if (ctrl_wr) begin
                tx_en_q <= pwdata[0];
                rx_en_q <= pwdata[1];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (idx)
            A_RXDATA: rdata[DATA_W-1:0] = rx_head;
            A_CFG:    rdata[4:0]        = cfg_q;
            A_CTRL:   rdata[1:0]        = {rx_en_q, tx_en_q};
            A_STATUS: begin
                rdata[4:0]   = sticky_q;
                rdata[5]     = tx_empty;
                rdata[6]     = tx_full;
                rdata[7]     = rx_empty;
                rdata[8]     = rx_full;
                rdata[15:9]  = 7'(tx_level);
                rdata[22:16] = 7'(rx_level);
            end
            A_IRQEN:  rdata[4:0]        = irq_en_q;
            default:  rdata = '0;
        endcase
    end

    assign prdata    = rd_ok ? rdata : 32'd0;
    assign unused_ok = ^pwdata[31:DATA_W];
endmodule

// File: tb/tb_apb_uart_regs_fifo.sv
// Directed bench for apb_uart_regs_fifo with TX/RX scoreboard queues.
module tb_apb_uart_regs_fifo;
    localparam int DW = 8;

    logic          pclk = 1'b0, preset = 1'b1;
    logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [4:0]    paddr = '0;
    logic [31:0]   pwdata = '0, prdata;
    logic          pready, pslverr;
    logic [DW-1:0] tx_data, rx_data = '0;
    logic          tx_valid, tx_ready = 1'b0, rx_valid = 1'b0;
    logic          tx_done_pulse = 1'b0, parity_err_pulse = 1'b0;
    logic [4:0]    cfg_out;
    logic          irq;

    int errors = 0, checks = 0;
    logic [DW-1:0] txq[$], rxq[$];
    logic          last_pready;
    logic [31:0]   rd_v;
    logic          err_v;

    apb_uart_regs_fifo #(.DATA_W(DW), .DEPTH(8)) dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_done_pulse(tx_done_pulse), .parity_err_pulse(parity_err_pulse),
        .cfg_out(cfg_out), .irq(irq)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One APB transfer; rx/parity events can be made to coincide with the access phase.
    task automatic apb_x(input logic wr, input logic [4:0] a, input logic [31:0] d,
                         input logic rxv, input logic [DW-1:0] rxd, input logic par,
                         output logic [31:0] rd, output logic err);
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge pclk);
        penable = 1'b1; rx_valid = rxv; rx_data = rxd; parity_err_pulse = par;
        #1 rd = prdata; err = pslverr; last_pready = pready;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; rx_valid = 1'b0; parity_err_pulse = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [4:0] a, input logic [31:0] d,
                          input logic exp_err);
        logic [31:0] r;
        logic e;
        apb_x(1'b1, a, d, 1'b0, '0, 1'b0, r, e);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp,
                          input logic exp_err);
        logic [31:0] r;
        logic e;
        apb_x(1'b0, a, 32'd0, 1'b0, '0, 1'b0, r, e);
        chk(tag, r, exp);
        chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    endtask

    task automatic rx_push(input logic [DW-1:0] c);
        @(negedge pclk); rx_valid = 1'b1; rx_data = c;
        @(negedge pclk); rx_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge pclk);
        #1;
        chk("rst_prdata", prdata, 0);
        chk("rst_pready", {31'd0, pready}, 0);
        chk("rst_pslverr", {31'd0, pslverr}, 0);
        chk("rst_tx", {23'd0, tx_valid, tx_data}, 0);
        chk("rst_cfg_irq", {26'd0, irq, cfg_out}, 0);
        @(negedge pclk); preset = 1'b0;

        rd_chk("cfg0", 5'h08, 0, 0);
        chk("pready_access", {31'd0, last_pready}, 1);
        rd_chk("ctrl0", 5'h0C, 0, 0);
        rd_chk("irqen0", 5'h14, 0, 0);
        rd_chk("status0", 5'h10, 32'h0000_00A0, 0);
        rd_chk("unmapped", 5'h18, 0, 1);
        rd_chk("misaligned", 5'h01, 0, 1);
        rd_chk("rd_txdata", 5'h00, 0, 1);
        wr_chk("wr_rxdata", 5'h04, 32'h55, 1);
        wr_chk("cfg_wr", 5'h08, 32'hFFFF_FFFF, 0);
        rd_chk("cfg_rd", 5'h08, 32'h1F, 0);
        chk("cfg_out", {27'd0, cfg_out}, 32'h1F);

        // Fill TX with tx_en=0, then overflow
        for (int i = 0; i < 8; i++) begin
            wr_chk("tx_fill", 5'h00, 32'h11 + i, 0);
            txq.push_back(DW'(8'h11 + i));
        end
        rd_chk("status_txfull", 5'h10, 32'h0000_10C0, 0);
        wr_chk("tx_overflow", 5'h00, 32'h19, 1);
        rd_chk("status_txovf", 5'h10, 32'h0000_10D0, 0);

        // Drain TX against the scoreboard
        tx_ready = 1'b1;
        wr_chk("ctrl_txen", 5'h0C, 32'h1, 0);
        for (int i = 0; i < 40 && txq.size() > 0; i++) begin
            @(negedge pclk); #1;
            if (tx_valid) chk("tx_data", {24'd0, tx_data}, {24'd0, txq.pop_front()});
        end
        chk("tx_drained", txq.size(), 0);
        @(negedge pclk); #1;
        chk("tx_valid_idle", {31'd0, tx_valid}, 0);
        tx_ready = 1'b0;
        wr_chk("w1c_ovf", 5'h10, 32'h10, 0);
        rd_chk("status_clr", 5'h10, 32'h0000_00A0, 0);

        // RX fill with overrun
        wr_chk("ctrl_rxen", 5'h0C, 32'h3, 0);
        for (int i = 0; i < 9; i++) begin
            rx_push(DW'(8'hA0 + i));
            if (i < 8) rxq.push_back(DW'(8'hA0 + i));
        end
        rd_chk("status_rxfull", 5'h10, 32'h0008_012A, 0);
        wr_chk("w1c_rx", 5'h10, 32'h0A, 0);

        // Full RX: pop and push in the same cycle
        apb_x(1'b0, 5'h04, 32'd0, 1'b1, 8'hB0, 1'b0, rd_v, err_v);
        chk("rx_popush_data", rd_v, {24'd0, rxq.pop_front()});
        chk("rx_popush_err", {31'd0, err_v}, 0);
        rxq.push_back(8'hB0);
        rd_chk("status_popush", 5'h10, 32'h0008_0122, 0);
        wr_chk("w1c_avail", 5'h10, 32'h02, 0);

        for (int i = 0; i < 8; i++) rd_chk("rxdata", 5'h04, {24'd0, rxq.pop_front()}, 0);
        rd_chk("rx_underflow", 5'h04, 0, 1);

        // Interrupts and W1C vs set
        wr_chk("irqen_wr", 5'h14, 32'h04, 0);
        chk("irq_idle", {31'd0, irq}, 0);
        @(negedge pclk); parity_err_pulse = 1'b1;
        @(negedge pclk); parity_err_pulse = 1'b0;
        #1 chk("irq_set", {31'd0, irq}, 1);
        wr_chk("w1c_par", 5'h10, 32'h04, 0);
        chk("irq_clr", {31'd0, irq}, 0);
        apb_x(1'b1, 5'h10, 32'h04, 1'b0, '0, 1'b1, rd_v, err_v);
        chk("irq_set_wins", {31'd0, irq}, 1);
        rd_chk("status_par", 5'h10, 32'h0000_00A4, 0);

        // TX flush keeps sticky state
        @(negedge pclk); tx_done_pulse = 1'b1;
        @(negedge pclk); tx_done_pulse = 1'b0;
        wr_chk("ctrl_tx_only", 5'h0C, 32'h1, 0);
        for (int i = 0; i < 4; i++) wr_chk("tx_fill4", 5'h00, 32'h61 + i, 0);
        chk("tx_head4", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h61});
        wr_chk("ctrl_flush", 5'h0C, 32'h5, 0);
        chk("flush_tx", {23'd0, tx_valid, tx_data}, 0);
        rd_chk("status_flush", 5'h10, 32'h0000_00A5, 0);
        rd_chk("ctrl_rd", 5'h0C, 32'h1, 0);

        // Reset in the middle of a TXDATA write
        @(negedge pclk);
        psel = 1'b1; pwrite = 1'b1; paddr = 5'h00; pwdata = 32'h55;
        @(negedge pclk); penable = 1'b1;
        #1 preset = 1'b1;
        @(posedge pclk);
        #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(negedge pclk); #1;
        chk("mrst_apb", {pready, pslverr, prdata[29:0]}, 0);
        chk("mrst_tx", {23'd0, tx_valid, tx_data}, 0);
        chk("mrst_cfg_irq", {26'd0, irq, cfg_out}, 0);
        preset = 1'b0;
        rd_chk("mrst_status", 5'h10, 32'h0000_00A0, 0);
        rd_chk("mrst_cfg", 5'h08, 0, 0);
        wr_chk("post_ctrl", 5'h0C, 32'h1, 0);
        wr_chk("post_tx", 5'h00, 32'h5A, 0);
        chk("tx_latency", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h5A});
        rd_chk("post_status", 5'h10, 32'h0000_0280, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_uart_regs_fifo.md
# apb_uart_regs_fifo

Parametrised APB3 register file for the UART. It replaces the single-byte TX/RX holding registers with TX and RX FIFOs of configurable depth and width. It adds sticky status with write-1-to-clear, overrun detection, interrupt enables and a level interrupt. It sits between the APB bus and the UART TX/RX cores and hands data to them over valid/ready handshakes.

## Interface
Parameters:
- DATA_W, 8: UART character width, 5..9; FIFO entry width.
- DEPTH, 8: entries per FIFO; power of two, 2..64.
- PTR_W, $clog2(DEPTH): FIFO pointer width; level counters are PTR_W+1 bits.

Ports (clock and reset first):
- pclk input 1: single clock, everything is synchronous to its rising edge.
- preset input 1: asynchronous, active-high reset; clears all state.
- psel, penable, pwrite input 1 each: APB3 control.
- paddr input 5: byte address.
- pwdata input 32: write data.
- prdata output 32: read data.
- pready output 1: transfer ready.
- pslverr output 1: transfer error.
- tx_data output DATA_W: head of the TX FIFO.
- tx_valid output 1: TX FIFO is not empty and CTRL.tx_en is set.
- tx_ready input 1: TX core accepts the head entry; pops the FIFO on tx_valid & tx_ready.
- rx_data input DATA_W, rx_valid input 1: RX core pushes a character, one cycle per character.
- tx_done_pulse, parity_err_pulse input 1 each: one-cycle events from the cores.
- cfg_out output 5: CFG[4:0], i.e. data_bits[1:0], stop[2], par_en[3], par_odd[4].
- irq output 1: level interrupt.

## Operation
- APB3 with zero wait states.
  - pready = psel & penable, driven combinationally.
  - prdata and pslverr are combinational during the access phase; prdata is 0 when no access is in progress.
  - Side effects (push, pop, W1C, register write) take effect on the rising edge that ends the access phase, and only if pslverr=0.
- Register map:
  - 0x00 TXDATA, WO: pushes pwdata[DATA_W-1:0] into the TX FIFO.
  - 0x04 RXDATA, RO: returns the RX FIFO head zero-extended to 32 bits, then pops it.
  - 0x08 CFG, RW: bits [4:0]; upper bits read as 0.
  - 0x0C CTRL, RW: [0] tx_en, [1] rx_en, [2] tx_flush, [3] rx_flush. The flush bits are self-clearing and always read 0.
  - 0x10 STATUS:
    - Sticky, W1C: [0] tx_done, [1] rx_avail_evt, [2] parity_err, [3] rx_overrun, [4] tx_overflow.
    - Read-only live values: [5] tx_empty, [6] tx_full, [7] rx_empty, [8] rx_full, [15:9] tx_level, [22:16] rx_level.
  - 0x14 IRQ_EN, RW: [4:0], same bit positions as the STATUS sticky bits.
- pslverr=1 for any of the following:
  - unmapped address;
  - paddr[1:0] != 0;
  - read of TXDATA;
  - write of RXDATA;
  - write of TXDATA while the TX FIFO is full (tx_overflow is set, data is dropped);
  - read of RXDATA while the RX FIFO is empty (prdata=0, no pop).
- RX push occurs when rx_valid & rx_en.
  - If the RX FIFO is full, the character is dropped and rx_overrun is set.
  - rx_avail_evt is set on every successful push.
  - rx_valid is ignored while rx_en=0.
- tx_done_pulse sets tx_done; parity_err_pulse sets parity_err.
- Simultaneous set and W1C of the same bit: set wins, the bit stays 1.
- Simultaneous push and pop on a FIFO: both happen and the level is unchanged. For a full FIFO this applies to TX pop+push and RX APB-pop+rx push, so neither errors. For an empty FIFO, pop is blocked and the push alone happens.
- Flush: the write to CTRL with the flush bit set resets that FIFO's pointers and level at the end of the access phase.
  - A same-cycle push into the flushed FIFO is discarded.
  - Sticky status is not affected.
- irq = |(STATUS[4:0] & IRQ_EN[4:0]), combinational from registered state.
- Levels and pointers wrap modulo DEPTH; level ranges 0..DEPTH.

## Timing
- Reset values:
  - prdata=0, pready=0, pslverr=0, tx_data=0, tx_valid=0, cfg_out=0, irq=0.
  - All registers 0, both FIFOs empty.
  - FIFO storage need not be reset; tx_data is 0 whenever the TX FIFO is empty.
- TXDATA write to an empty FIFO with tx_en=1: tx_valid rises the cycle after the access edge; latency is 1.
- TX handshake: tx_data and tx_valid are stable until tx_ready is sampled high. The next entry appears on the cycle after the pop.
- RX latency: after a push at edge N, RXDATA is readable and rx_level is updated in the access phase following edge N.
- Clearing tx_en mid-stream drops tx_valid combinationally; the FIFO contents are retained.
- Reset asserted mid-transfer clears everything immediately, with no pending side effects. The first access after deassertion behaves normally.

## Test plan
- Reset then read every register:
  - CFG, CTRL, IRQ_EN read 0.
  - STATUS reads 0x000000A0 (tx_empty, rx_empty).
  - Unmapped 0x18 and misaligned 0x01 give pslverr=1.
- DEPTH=8, tx_en=0:
  - Write 0x11..0x18 → tx_level=8, tx_full=1.
  - A ninth write of 0x19 → pslverr=1 and STATUS[4]=1.
  - Set tx_en with tx_ready=1 → tx_data sequence 0x11..0x18 in order, then tx_valid=0.
- rx_en=1:
  - Push 9 characters 0xA0..0xA8 → rx_full, rx_overrun=1, and 0xA8 is dropped.
  - 8 RXDATA reads return 0xA0..0xA7.
  - A ninth read → prdata=0, pslverr=1.
- IRQ_EN=0x04, then a parity_err_pulse → irq=1 next cycle.
  - Write STATUS=0x04 → irq=0.
  - Repeat the W1C in the same cycle as a new pulse → the bit stays 1.
- Full RX FIFO: an RXDATA pop in the same cycle as an rx_valid push → no overrun, level stays 8, and FIFO order is preserved.
- Fill TX with 4 entries, write CTRL=0x4 → tx_level=0, tx_valid=0, tx_done unchanged. Then assert preset mid-write → all outputs return to reset values.
